// File: rtl/dp_sequencer.sv
// Multi-cycle control sequencer for the 16-bit register bank / ALU datapath.
// Optional flag register enabled by defining CTRL_FLAGS_EN.
module dp_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    input  logic [15:0] instr,
    output logic        instr_ready,
    output logic [2:0]  pa,
    output logic        rdr,
    output logic        ldx,
    output logic        ldy,
    output logic [2:0]  fsel,
    output logic        ldz,
    output logic [2:0]  wp,
    output logic        wrr,
    output logic        dsel,
    input  logic        c,
    input  logic        v,
    input  logic        s,
    input  logic        z_det,
    output logic [3:0]  flags,
    output logic        done
);

    typedef enum logic [2:0] {
        StIdle,
        StRdX,
        StRdY,
        StExec,
        StWrite,
        StFin
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] ir_q;
    logic        accept;

    logic [2:0]  ir_fsel, ir_rd, ir_rs1, ir_rs2;
    logic        ir_ext;

    assign ir_fsel = ir_q[15:13];
    assign ir_rd   = ir_q[12:10];
    assign ir_rs1  = ir_q[9:7];
    assign ir_rs2  = ir_q[6:4];
    assign ir_ext  = ir_q[3];

    assign accept = instr_valid & instr_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ir_q    <= 16'h0000;
        end else begin
            state_q <= state_d;
            if (accept) begin
                ir_q <= instr;
            end
        end
    end

    // Next-state decode looks at the incoming word in IDLE, at the IR elsewhere.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (instr[3]) begin
                        state_d = StWrite;
                    end else if (instr[15:13] == 3'b101) begin
                        state_d = StFin;
                    end else begin
                        state_d = StRdX;
                    end
                end
            end
            StRdX:   state_d = ir_fsel[2] ? StExec : StRdY;
            StRdY:   state_d = StExec;
            StExec:  state_d = StWrite;
            StWrite: state_d = StFin;
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        instr_ready = 1'b0;
        pa          = 3'b000;
        rdr         = 1'b0;
        ldx         = 1'b0;
        ldy         = 1'b0;
        fsel        = 3'b000;
        ldz         = 1'b0;
        wp          = 3'b000;
        wrr         = 1'b0;
        dsel        = 1'b0;
        done        = 1'b0;
        if (state_q != StIdle) begin
            fsel = ir_fsel;
        end
        unique case (state_q)
            StIdle: instr_ready = 1'b1;
            StRdX: begin
                pa  = ir_rs1;
                rdr = 1'b1;
                ldx = 1'b1;
            end
            StRdY: begin
                pa  = ir_rs2;
                rdr = 1'b1;
                ldy = 1'b1;
            end
            StExec: ldz = 1'b1;
            StWrite: begin
                wp   = ir_rd;
                wrr  = 1'b1;
                dsel = ir_ext;
            end
            StFin: done = 1'b1;
            default: ;
        endcase
    end

`ifdef CTRL_FLAGS_EN
    logic [3:0] flags_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= 4'b0000;
        end else if (state_q == StExec) begin
            flags_q <= {c, v, s, z_det};
        end
    end

    assign flags = flags_q;

    logic unused_ir;
    assign unused_ir = ^ir_q[2:0];
`else
    assign flags = 4'b0000;

    logic unused_in;
    assign unused_in = ^{c, v, s, z_det, ir_q[2:0]};
`endif

endmodule

// File: tb/tb_dp_sequencer.sv
// Self-checking bench for dp_sequencer: per-cycle schedule model plus directed literal checks.
module tb_dp_sequencer;

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;
    logic [2:0]  pa;
    logic        rdr;
    logic        ldx;
    logic        ldy;
    logic [2:0]  fsel;
    logic        ldz;
    logic [2:0]  wp;
    logic        wrr;
    logic        dsel;
    logic        c;
    logic        v;
    logic        s;
    logic        z_det;
    logic [3:0]  flags;
    logic        done;

    int checks = 0;
    int errors = 0;

`ifdef CTRL_FLAGS_EN
    localparam logic [3:0] FlExp = 4'b1010;
`else
    localparam logic [3:0] FlExp = 4'b0000;
`endif

    dp_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .pa          (pa),
        .rdr         (rdr),
        .ldx         (ldx),
        .ldy         (ldy),
        .fsel        (fsel),
        .ldz         (ldz),
        .wp          (wp),
        .wrr         (wrr),
        .dsel        (dsel),
        .c           (c),
        .v           (v),
        .s           (s),
        .z_det       (z_det),
        .flags       (flags),
        .done        (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Flag inputs: random every cycle unless a fixed pattern is requested.
    logic       rand_fl  = 1'b1;
    logic [3:0] fl_fixed = 4'b0000;
    always @(negedge clk) begin
        if (rand_fl) {c, v, s, z_det} = 4'($urandom_range(0, 15));
        else         {c, v, s, z_det} = fl_fixed;
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp_v);
        end
    endtask

    // Expected outputs for one cycle; the queue front is the current cycle, empty means idle.
    typedef struct packed {
        logic       ready;
        logic [2:0] pa;
        logic       rdr;
        logic       ldx;
        logic       ldy;
        logic [2:0] fsel;
        logic       ldz;
        logic [2:0] wp;
        logic       wrr;
        logic       dsel;
        logic       done;
        logic       exec;
    } ent_t;

    ent_t       sched[$];
    logic [3:0] exp_flags = 4'b0000;

    function automatic void build(input logic [15:0] w);
        ent_t       e;
        logic [2:0] fs;
        fs = w[15:13];
        if (w[3]) begin
            e = '0; e.fsel = fs; e.wp = w[12:10]; e.wrr = 1'b1; e.dsel = 1'b1;
            sched.push_back(e);
        end else if (fs != 3'b101) begin
            e = '0; e.fsel = fs; e.pa = w[9:7]; e.rdr = 1'b1; e.ldx = 1'b1;
            sched.push_back(e);
            if (!fs[2]) begin
                e = '0; e.fsel = fs; e.pa = w[6:4]; e.rdr = 1'b1; e.ldy = 1'b1;
                sched.push_back(e);
            end
            e = '0; e.fsel = fs; e.ldz = 1'b1; e.exec = 1'b1;
            sched.push_back(e);
            e = '0; e.fsel = fs; e.wp = w[12:10]; e.wrr = 1'b1;
            sched.push_back(e);
        end
        e = '0; e.fsel = fs; e.done = 1'b1;
        sched.push_back(e);
    endfunction

    // Model advance on each edge, then compare every output just after it.
    always @(posedge clk) begin
        ent_t cur;
        if (!rst_n) begin
            sched.delete();
            exp_flags = 4'b0000;
        end else if (sched.size() == 0) begin
            if (instr_valid) build(instr);
        end else begin
`ifdef CTRL_FLAGS_EN
            if (sched[0].exec) exp_flags = {c, v, s, z_det};
`endif
            void'(sched.pop_front());
        end
        #1;
        if (sched.size() == 0) begin
            cur = '0;
            cur.ready = 1'b1;
        end else begin
            cur = sched[0];
        end
        chk("m_ready", 16'(instr_ready), 16'(cur.ready));
        chk("m_pa",    16'(pa),          16'(cur.pa));
        chk("m_rdr",   16'(rdr),         16'(cur.rdr));
        chk("m_ldx",   16'(ldx),         16'(cur.ldx));
        chk("m_ldy",   16'(ldy),         16'(cur.ldy));
        chk("m_fsel",  16'(fsel),        16'(cur.fsel));
        chk("m_ldz",   16'(ldz),         16'(cur.ldz));
        chk("m_wp",    16'(wp),          16'(cur.wp));
        chk("m_wrr",   16'(wrr),         16'(cur.wrr));
        chk("m_dsel",  16'(dsel),        16'(cur.dsel));
        chk("m_done",  16'(done),        16'(cur.done));
        chk("m_flags", 16'(flags),       16'(exp_flags));
    end

    // Leaves the caller at the sampling point of the first cycle after the accept edge.
    task automatic send(input logic [15:0] w);
        @(negedge clk);
        instr       = w;
        instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr       = 16'h0000;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_ready", 16'(instr_ready), 16'd1);
        chk("rst_wrr",   16'(wrr),         16'd0);
        chk("rst_done",  16'(done),        16'd0);
        chk("rst_flags", 16'(flags),       16'd0);
        @(negedge clk) rst_n = 1'b1;
        step();

        // Binary add: fsel=000 rd=3 rs1=1 rs2=1
        send(16'h0C90);
        chk("add_c1_pa",  16'(pa), 16'd1);
        chk("add_c1_ldx", 16'(ldx), 16'd1);
        chk("add_c1_rdy", 16'(instr_ready), 16'd0);
        step();
        chk("add_c2_pa",  16'(pa), 16'd1);
        chk("add_c2_ldy", 16'(ldy), 16'd1);
        step();
        chk("add_c3_ldz", 16'(ldz), 16'd1);
        chk("add_c3_fsel", 16'(fsel), 16'd0);
        step();
        chk("add_c4_wp",  16'(wp), 16'd3);
        chk("add_c4_wrr", 16'(wrr), 16'd1);
        chk("add_c4_dsel", 16'(dsel), 16'd0);
        step();
        chk("add_c5_done", 16'(done), 16'd1);
        chk("add_c5_rdy", 16'(instr_ready), 16'd0);
        step();
        chk("add_c6_rdy", 16'(instr_ready), 16'd1);

        // Unary negate: fsel=100 rd=2 rs1=5
        send(16'h8A80);
        chk("neg_c1_pa", 16'(pa), 16'd5);
        step();
        chk("neg_c2_ldz", 16'(ldz), 16'd1);
        chk("neg_c2_ldy", 16'(ldy), 16'd0);
        chk("neg_c2_fsel", 16'(fsel), 16'd4);
        step();
        chk("neg_c3_wp", 16'(wp), 16'd2);
        step();
        chk("neg_c4_done", 16'(done), 16'd1);
        step();

        // Sub with fixed flags {c,v,s,z}=1010 at EXEC
        fl_fixed = 4'b1010;
        rand_fl  = 1'b0;
        send(16'h2530);
        step();
        step();
        chk("sub_c3_ldz", 16'(ldz), 16'd1);
        step();
        rand_fl = 1'b1;
        chk("sub_flags", 16'(flags), 16'(FlExp));
        step();
        chk("sub_c5_done", 16'(done), 16'd1);
        step();

        // Ext load rd=7
        send(16'h1C08);
        chk("ext_c1_wp",   16'(wp), 16'd7);
        chk("ext_c1_wrr",  16'(wrr), 16'd1);
        chk("ext_c1_dsel", 16'(dsel), 16'd1);
        chk("ext_c1_rdr",  16'(rdr), 16'd0);
        step();
        chk("ext_c2_done", 16'(done), 16'd1);
        chk("ext_flags",   16'(flags), 16'(FlExp));
        step();

        // NOP
        send(16'hA000);
        chk("nop_c1_done", 16'(done), 16'd1);
        chk("nop_c1_wrr",  16'(wrr), 16'd0);
        chk("nop_c1_ldz",  16'(ldz), 16'd0);
        chk("nop_flags",   16'(flags), 16'(FlExp));
        step();
        chk("nop_c2_rdy",  16'(instr_ready), 16'd1);

        // Reset asserted during WRITE of a binary op with rd=3
        send(16'h0C90);
        step();
        step();
        step();
        chk("mrst_pre_wrr", 16'(wrr), 16'd1);
        #3 rst_n = 1'b0;
        #1;
        chk("mrst_wrr",   16'(wrr), 16'd0);
        chk("mrst_ready", 16'(instr_ready), 16'd1);
        chk("mrst_flags", 16'(flags), 16'd0);
        chk("mrst_done",  16'(done), 16'd0);
        step();
        chk("mrst_done2", 16'(done), 16'd0);
        @(negedge clk) rst_n = 1'b1;
        step();
        chk("mrst_post_done", 16'(done), 16'd0);
        chk("mrst_post_wrr",  16'(wrr), 16'd0);

        // Randomized traffic, occasional resets
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            instr_valid = 1'($urandom_range(0, 1));
            instr       = 16'($urandom);
            instr[3]    = ($urandom_range(0, 3) == 0);
            rst_n       = ($urandom_range(0, 299) != 0);
        end
        @(negedge clk);
        instr_valid = 1'b0;
        rst_n       = 1'b1;
        repeat (8) @(posedge clk);
        #3;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dp_sequencer.md
# dp_sequencer

Multi-cycle control sequencer that drives the 16-bit register bank and ALU datapath. It accepts one instruction word at a time through a valid/ready handshake and plays the register bank's single read port, the X/Y/Z operand latches, the ALU function select and the register-bank write port in a fixed state sequence. It sits between instruction fetch and the datapath as the initiator of every register-bank and ALU transaction.

## Interface
Parameters: none.

- clk  in  1  rising-edge clock, shared with the register bank
- rst_n  in  1  asynchronous active-low reset
- instr_valid  in  1  instruction word offered
- instr  in  16  instruction word: [15:13] fsel, [12:10] rd, [9:7] rs1, [6:4] rs2, [3] ext (load ext_data), [2:0] reserved
- instr_ready  out  1  sequencer can accept an instruction
- pa  out  3  register-bank read address
- rdr  out  1  register-bank read enable
- ldx  out  1  load ALU X latch from bank read data
- ldy  out  1  load ALU Y latch from bank read data
- fsel  out  3  ALU function select
- ldz  out  1  load ALU result latch
- wp  out  3  register-bank write address
- wrr  out  1  register-bank write enable
- dsel  out  1  write-data select: 0 = ALU result latch, 1 = ext_data
- c, v, s, z_det  in  1 each  ALU flags
- flags  out  4  latched {C,V,S,Z}
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, RD_X, RD_Y, EXEC, WRITE, FIN.
- Instruction register IR captures instr on the accept edge (instr_valid & instr_ready).
- All datapath outputs are combinational decodes of state and IR. They are 0 outside their own state.
- IDLE: instr_ready=1. On accept:
  - ext=1 -> WRITE.
  - else fsel=101 (NOP/hold) -> FIN.
  - else -> RD_X.
- RD_X: pa=rs1, rdr=1, ldx=1.
  - fsel[2]=1 (unary: negate 100, transfer 110/111) -> EXEC.
  - else -> RD_Y.
- RD_Y: pa=rs2, rdr=1, ldy=1 -> EXEC.
- EXEC: fsel=IR fsel, ldz=1; flags captured (see Configuration) -> WRITE.
- WRITE: wp=rd, wrr=1, dsel=ext -> FIN.
- FIN: done=1 (registered, high exactly this cycle) -> IDLE.
- fsel is driven with IR fsel in every non-IDLE state, so ALU inputs stay stable. It is 000 in IDLE.
- Reserved bits [2:0] are ignored. ext=1 ignores fsel, rs1 and rs2.
- Writing rd equal to rs1 or rs2 is legal: operands were latched in earlier states.

## Timing
- Reset (rst_n low, asynchronous): state=IDLE, IR=0, flags=0, done=0. Every decoded output is 0 except instr_ready=1. No accept can occur while rst_n is low.
- Reset asserted mid-sequence aborts immediately: wrr drops in the same cycle, and no partial write completes on the next edge.
- Latency from the accept edge to the done cycle:
  - binary op: 5 cycles (RD_X, RD_Y, EXEC, WRITE, FIN)
  - unary op: 4 cycles
  - ext load: 2 cycles
  - NOP: 1 cycle
- instr_ready is low from the accept edge until the return to IDLE, so there is at least one idle cycle between instructions.
- instr_valid may drop or change while busy; it is ignored.

## Configuration
- CTRL_FLAGS_EN defined: a 4-bit flag register loads {c,v,s,z_det} on the EXEC edge and holds through ext loads, NOPs and idle time. It resets to 0.
- Undefined: no flag flops; flags is tied to 4'b0000 and the ALU flag inputs are unused.

## Test plan
- Reset mid-WRITE (binary op, rd=3): assert rst_n low during WRITE -> wrr=0 in the same cycle, instr_ready=1, flags=0, no done pulse.
- Binary add, instr=16'h0C90 (fsel=000, rd=3, rs1=1, rs2=1): pa=1 with ldx, then pa=1 with ldy, ldz with fsel=000, wp=3 with wrr=1 and dsel=0, done on cycle 5; instr_ready low throughout.
- Unary negate, fsel=100, rs1=5, rd=2: RD_Y skipped, ldy never asserted, wp=2 on cycle 3, done on cycle 4.
- Ext load, ext=1, rd=7: WRITE on the first cycle after accept with wp=7, wrr=1, dsel=1; done on cycle 2; no rdr/ldx/ldz activity.
- NOP, fsel=101: done on the cycle after accept; wrr, rdr and ldz stay 0; flags unchanged.
- With CTRL_FLAGS_EN, sub with c=1, v=0, s=1, z_det=0 at EXEC -> flags=4'b1010, held through a following ext load. Without the macro -> flags=0.
